// File: rtl/cycle_stats_pkg.sv
// Shared encodings for the cycle statistics block: command opcodes,
// READ selectors, STATUS bit positions and the control FSM state type.
package cycle_stats_pkg;

  typedef enum logic [1:0] {
    CMD_CLEAR  = 2'd0,
    CMD_ADD    = 2'd1,
    CMD_READ   = 2'd2,
    CMD_STATUS = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    SEL_COUNT = 2'd0,
    SEL_SUM   = 2'd1,
    SEL_MIN   = 2'd2,
    SEL_MAX   = 2'd3
  } sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int STATUS_OVF_BIT   = 0;
  localparam int STATUS_EMPTY_BIT = 1;

endpackage

// File: rtl/cycle_stats_if.sv
// Command/result handshake bundle of cycle_stats; master is the side that
// issues commands and consumes results, slave is the statistics block.
interface cycle_stats_if #(
  parameter int WIDTH = 64
) ();

  logic [WIDTH-1:0] m_input_value;
  logic [1:0]       m_input_cmd;
  logic             m_valid_in;
  logic             m_ready_out;
  logic [WIDTH-1:0] m_output_value;
  logic             m_valid_out;
  logic             m_ready_in;

  modport master (
    output m_input_value,
    output m_input_cmd,
    output m_valid_in,
    output m_ready_in,
    input  m_ready_out,
    input  m_output_value,
    input  m_valid_out
  );

  modport slave (
    input  m_input_value,
    input  m_input_cmd,
    input  m_valid_in,
    input  m_ready_in,
    output m_ready_out,
    output m_output_value,
    output m_valid_out
  );

endinterface

// File: rtl/stats_accum.sv
// Statistics datapath: saturating count/sum, running unsigned min/max and a
// sticky overflow flag, updated by single-cycle clear/add strobes.
module stats_accum
  import cycle_stats_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clr,
  input  logic             add,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] min_val,
  output logic [WIDTH-1:0] max_val,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   sum_wide_s;
  logic             sum_carry_s;
  logic             count_full_s;

  // Next-state datapath; the extra sum bit detects that the true sum no longer fits
  always_comb begin
    sum_wide_s   = {1'b0, sum_q} + {1'b0, sample};
    sum_carry_s  = sum_wide_s[WIDTH];
    count_full_s = &count_q;
    count_d      = count_q;
    sum_d        = sum_q;
    min_d        = min_q;
    max_d        = max_q;
    ovf_d        = ovf_q;
    if (clr) begin
      count_d = ZERO;
      sum_d   = ZERO;
      min_d   = ALL_ONES;
      max_d   = ZERO;
      ovf_d   = 1'b0;
    end else if (add) begin
      count_d = count_full_s ? count_q : (count_q + ONE);
      sum_d   = sum_carry_s ? ALL_ONES : sum_wide_s[WIDTH-1:0];
      min_d   = (sample < min_q) ? sample : min_q;
      max_d   = (sample > max_q) ? sample : max_q;
      ovf_d   = ovf_q | count_full_s | sum_carry_s;
    end else begin
      count_d = count_q;
      sum_d   = sum_q;
    end
  end

  // Statistics registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q <= ZERO;
      sum_q   <= ZERO;
      min_q   <= ALL_ONES;
      max_q   <= ZERO;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sum_q   <= sum_d;
      min_q   <= min_d;
      max_q   <= max_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;
  assign sum        = sum_q;
  assign min_val    = min_q;
  assign max_val    = max_q;
  assign ovf        = ovf_q;

endmodule

// File: rtl/cycle_stats.sv
// Cycle statistics block: accepts one command at a time, executes it against
// the stats_accum datapath in a single EXEC cycle and holds the result until taken.
module cycle_stats
  import cycle_stats_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] m_input_value,
  input  logic [1:0]       m_input_cmd,
  output logic             m_ready_out,
  input  logic             m_valid_in,
  output logic [WIDTH-1:0] m_output_value,
  output logic             m_valid_out,
  input  logic             m_ready_in
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  state_e           state_q, state_d;
  cmd_e             cmd_q, cmd_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             accept_s;
  logic             clr_s;
  logic             add_s;
  logic [WIDTH-1:0] exec_result_s;
  logic [WIDTH-1:0] count_s, count_next_s, sum_s, min_s, max_s;
  logic             ovf_s;

  assign accept_s = ready_q & m_valid_in;
  assign clr_s    = (state_q == ST_EXEC) && (cmd_q == CMD_CLEAR);
  assign add_s    = (state_q == ST_EXEC) && (cmd_q == CMD_ADD);

  stats_accum #(
    .WIDTH (WIDTH)
  ) u_accum (
    .clock      (clock),
    .resetn     (resetn),
    .clr        (clr_s),
    .add        (add_s),
    .sample     (value_q),
    .count      (count_s),
    .count_next (count_next_s),
    .sum        (sum_s),
    .min_val    (min_s),
    .max_val    (max_s),
    .ovf        (ovf_s)
  );

  // Result of the command in EXEC; ADD reports the count as it will be after the update
  always_comb begin
    exec_result_s = ZERO;
    case (cmd_q)
      CMD_CLEAR: exec_result_s = ZERO;
      CMD_ADD:   exec_result_s = count_next_s;
      CMD_READ: begin
        case (sel_e'(value_q[1:0]))
          SEL_COUNT: exec_result_s = count_s;
          SEL_SUM:   exec_result_s = sum_s;
          SEL_MIN:   exec_result_s = min_s;
          SEL_MAX:   exec_result_s = max_s;
          default:   exec_result_s = ZERO;
        endcase
      end
      CMD_STATUS: begin
        exec_result_s[STATUS_OVF_BIT]   = ovf_s;
        exec_result_s[STATUS_EMPTY_BIT] = (count_s == ZERO);
      end
      default: exec_result_s = ZERO;
    endcase
  end

  // Control FSM next state; ready/valid/result are precomputed so the outputs come straight from flops
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    value_d  = value_q;
    ready_d  = ready_q;
    valid_d  = valid_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_EXEC;
          cmd_d   = cmd_e'(m_input_cmd);
          value_d = m_input_value;
          ready_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      ST_EXEC: begin
        state_d  = ST_RESP;
        valid_d  = 1'b1;
        result_d = exec_result_s;
      end
      ST_RESP: begin
        if (m_ready_in) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end else begin
          state_d = ST_RESP;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        valid_d = 1'b0;
      end
    endcase
  end

  // Control registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cmd_q    <= CMD_CLEAR;
      value_q  <= ZERO;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      result_q <= ZERO;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      value_q  <= value_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  assign m_ready_out    = ready_q;
  assign m_valid_out    = valid_q;
  assign m_output_value = result_q;

endmodule

// File: doc/cycle_stats.md
CYCLE_STATS -- requirements
Module: cycle_stats

Interface
REQ-001 Parameter WIDTH SHALL be provided: default 64; width of sample, count, sum, min, max and result.
REQ-002 Port clock SHALL be provided: input, 1 bit; the single clock; all state on posedge.
REQ-003 Port resetn SHALL be provided: input, 1 bit; reset is asynchronous and active-low.
REQ-004 Port m_input_value SHALL be provided: input, WIDTH bits; sample for ADD, selector for READ.
REQ-005 Port m_input_cmd SHALL be provided: input, 2 bits; 0 CLEAR, 1 ADD, 2 READ, 3 STATUS.
REQ-006 Port m_ready_out SHALL be provided: output, 1 bit; block can accept a command.
REQ-007 Port m_valid_in SHALL be provided: input, 1 bit; upstream presents a command (typically the measured cycle count from the wait stage).
REQ-008 Port m_output_value SHALL be provided: output, WIDTH bits; result of the last command.
REQ-009 Port m_valid_out SHALL be provided: output, 1 bit; result valid.
REQ-010 Port m_ready_in SHALL be provided: input, 1 bit; downstream accepts the result.

Function
REQ-011 Accept SHALL occur on a rising edge with m_ready_out=1 and m_valid_in=1; m_input_value and m_input_cmd are captured at that edge.
REQ-012 FSM states SHALL be IDLE (ready_out=1), EXEC (one cycle, stats update), RESP (valid_out=1); transitions: IDLE->EXEC on accept, EXEC->RESP unconditionally, RESP->IDLE on valid_out & ready_in.
REQ-013 m_ready_out SHALL be 0 from the cycle after accept until the cycle after the output handshake; one transaction in flight.
REQ-014 m_valid_out SHALL rise exactly 2 cycles after the accept edge and hold, with m_output_value stable, until m_ready_in=1.
REQ-015 m_valid_in while m_ready_out=0 SHALL be ignored, with no state change.
REQ-016 CLEAR SHALL set count=0, sum=0, min=all-ones, max=0, ovf=0, and return 0.
REQ-017 ADD of sample s SHALL perform count+=1, sum+=s, min=min(min,s), max=max(max,s), and return the updated count.
REQ-018 count and sum SHALL saturate at 2^WIDTH-1; any saturating ADD sets the sticky ovf flag.
REQ-019 READ SHALL use selector m_input_value[1:0] to return 0 count, 1 sum, 2 min, 3 max; upper selector bits are ignored.
REQ-020 READ of min with count=0 SHALL return all-ones; READ of max with count=0 SHALL return 0.
REQ-021 STATUS SHALL return bit0=ovf and bit1=(count==0), with all other bits 0.
REQ-022 Comparisons SHALL be unsigned; no multi-cycle arithmetic.

Reset
REQ-023 resetn low SHALL force asynchronously: state=IDLE, m_ready_out=1, m_valid_out=0, m_output_value=0, count=0, sum=0, min=all-ones, max=0, ovf=0.
REQ-024 Reset asserted mid-transaction SHALL abort it; no result is emitted after release.
REQ-025 First accept SHALL be possible on the first rising edge after resetn deasserts.

Structure
REQ-026 Package cycle_stats_pkg SHALL hold the command encodings, selector encodings and FSM state type.
REQ-027 Datapath SHALL be sub-module stats_accum, holding count, sum, min, max and ovf with clear/add strobes; the FSM and handshake live in cycle_stats.

Verification
REQ-028 Reset release, then ADD 10, 30, 20 with READ sel 0..3 -> returns 1, 2, 3, then 3, 60, 10, 30.
REQ-029 Accept at edge T -> m_valid_out high at T+2; hold m_ready_in=0 for 5 cycles -> m_valid_out and value stable, m_ready_out=0 throughout; m_ready_out=1 the cycle after the handshake.
REQ-030 WIDTH=8: ADD 200, ADD 100 -> READ sum=255; STATUS=1.
REQ-031 CLEAR after activity -> returns 0; READ min=255 (WIDTH=8), READ max=0; STATUS=2.
REQ-032 Toggle m_valid_in with ADD 5 during EXEC/RESP -> ignored; READ count unchanged.
REQ-033 resetn pulsed low while in RESP -> m_valid_out drops immediately; after release READ count=0 and m_ready_out=1.
